// File: rtl/mem_region_controller.sv
// Registered memory region controller: instruction fetch path plus a data handshake decoded onto ROM/LUT/RAM.
// Optional sticky fault capture when MEMCTRL_FAULT_LATCH_EN is defined. Region parameters must not overlap.
module mem_region_controller #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int IMEM_SIZE   = 399,
  parameter int ROM_BASE    = 400,
  parameter int ROM_SIZE    = 90000,
  parameter int LUT_BASE    = 90400,
  parameter int LUT_SIZE    = 300,
  parameter int RAM_BASE    = 90700,
  parameter int RAM_SIZE    = 129600,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] instruction,
  output logic          instr_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [2:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] rom_rdata,
  input  logic [DW-1:0] lut_rdata,
  input  logic [DW-1:0] ram_rdata
`ifdef MEMCTRL_FAULT_LATCH_EN
  ,
  output logic [AW-1:0] fault_addr,
  output logic          fault_valid
`endif
);
  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | region selected, wait states counting down
  // RESP   | one-cycle response strobe
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [AW-1:0] IMEM_LIM = AW'(IMEM_SIZE);
  localparam logic [AW-1:0] ROM_LO   = AW'(ROM_BASE);
  localparam logic [AW-1:0] ROM_HI   = AW'(ROM_BASE + ROM_SIZE);
  localparam logic [AW-1:0] LUT_LO   = AW'(LUT_BASE);
  localparam logic [AW-1:0] LUT_HI   = AW'(LUT_BASE + LUT_SIZE);
  localparam logic [AW-1:0] RAM_LO   = AW'(RAM_BASE);
  localparam logic [AW-1:0] RAM_HI   = AW'(RAM_BASE + RAM_SIZE);
  localparam logic [3:0]    WS       = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [3:0]    wait_q;
  logic [2:0]    sel_q;
  logic [AW-1:0] off_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  logic          rom_hit, lut_hit, ram_hit, go_access;
  logic [2:0]    hit_sel;
  logic [AW-1:0] hit_off;
  logic [DW-1:0] rd_mux;

  assign imem_addr = pc;
  assign mem_wdata = wdata_q;

  assign rom_hit   = (d_addr >= ROM_LO) && (d_addr < ROM_HI);
  assign lut_hit   = (d_addr >= LUT_LO) && (d_addr < LUT_HI);
  assign ram_hit   = (d_addr >= RAM_LO) && (d_addr < RAM_HI);
  assign hit_sel   = {ram_hit, lut_hit, rom_hit};
  // Only RAM accepts writes; ROM/LUT writes take the error path like unmapped addresses.
  assign go_access = (|hit_sel) && (!d_we || ram_hit);

  always_comb begin
    hit_off = '0;
    if (rom_hit)      hit_off = d_addr - ROM_LO;
    else if (lut_hit) hit_off = d_addr - LUT_LO;
    else if (ram_hit) hit_off = d_addr - RAM_LO;
  end

  always_comb begin
    rd_mux = '0;
    if (sel_q[0])      rd_mux = rom_rdata;
    else if (sel_q[1]) rd_mux = lut_rdata;
    else if (sel_q[2]) rd_mux = ram_rdata;
  end

  always_comb begin
    state_d  = state_q;
    d_ready  = 1'b0;
    d_rvalid = 1'b0;
    mem_sel  = '0;
    mem_addr = '0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        d_ready = 1'b1;
        if (d_req) state_d = go_access ? ACCESS : RESP;
      end
      ACCESS: begin
        mem_sel  = sel_q;
        mem_addr = off_q;
        // Counter still at its load value marks the first ACCESS cycle.
        mem_we   = we_q && (wait_q == WS);
        if (wait_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        d_rvalid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      sel_q       <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
`ifdef MEMCTRL_FAULT_LATCH_EN
      fault_addr  <= '0;
      fault_valid <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instruction <= (pc < IMEM_LIM) ? imem_data : '0;
      instr_valid <= (pc < IMEM_LIM);
      case (state_q)
        IDLE: begin
          if (d_req) begin
            off_q   <= hit_off;
            we_q    <= d_we && go_access;
            wdata_q <= d_wdata;
            if (go_access) begin
              sel_q  <= hit_sel;
              wait_q <= WS;
            end else begin
              sel_q   <= '0;
              d_rdata <= '0;
              d_err   <= 1'b1;
`ifdef MEMCTRL_FAULT_LATCH_EN
              if (!fault_valid) begin
                fault_addr  <= d_addr;
                fault_valid <= 1'b1;
              end
`endif
            end
          end
        end
        ACCESS: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            d_rdata <= we_q ? '0 : rd_mux;
            d_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mem_region_controller.md
# mem_region_controller

Parametrised, registered successor to the processor's address-decoding memory controller. It maps the processor's data bus onto three backing memories (pixel ROM, sine LUT, data RAM) through base/size parameters. Data accesses use a request/ready/valid handshake with programmable wait states, write protection and an unmapped-address error. Instruction fetch is a separate registered path. It sits between the processor core and the memory instances, and replaces latch-based decoding with fully clocked behaviour.

## Interface
Parameters:
- DW, 32, data width
- AW, 32, address width
- IMEM_SIZE, 399, instruction words; valid fetch is pc < IMEM_SIZE
- ROM_BASE, 400 / ROM_SIZE, 90000, pixel ROM region (read-only)
- LUT_BASE, 90400 / LUT_SIZE, 300, sine LUT region (read-only)
- RAM_BASE, 90700 / RAM_SIZE, 129600, data RAM region (read/write)
- WAIT_STATES, 0, extra ACCESS cycles before read data is sampled (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc  in  AW  instruction fetch address
- imem_addr  out  AW  instruction memory address; equals pc, combinational
- imem_data  in  DW  instruction memory data
- instruction  out  DW  registered fetched instruction
- instr_valid  out  1  registered; high when the sampled pc was in range
- d_req  in  1  data request
- d_we  in  1  request is a write
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ready  out  1  controller can accept a request
- d_rvalid  out  1  one-cycle response strobe (reads and writes)
- d_rdata  out  DW  read data, valid with d_rvalid
- d_err  out  1  error flag, valid with d_rvalid
- mem_sel  out  3  one-hot {RAM, LUT, ROM}
- mem_addr  out  AW  region-relative address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DW  RAM write data
- rom_rdata, lut_rdata, ram_rdata  in  DW  backing memory read data, combinational from mem_addr

## Operation
- Instruction path: each cycle, instruction <= (pc < IMEM_SIZE) ? imem_data : 0, and instr_valid <= (pc < IMEM_SIZE).
- Decode on accept: region hit when BASE <= d_addr < BASE+SIZE, compared at AW bits. Offset = d_addr - BASE. Region parameters must not overlap; overlap is a parameter error.
- FSM states IDLE, ACCESS, RESP.
- IDLE: d_ready=1. With d_req=1, latch addr/offset/we/wdata and region.
  - Mapped region, and a read or a write to RAM: go to ACCESS.
  - Unmapped, or a write to ROM/LUT: go to RESP with err=1 and rdata=0. mem_sel is never asserted and mem_we is never pulsed.
- ACCESS: mem_sel and mem_addr are driven from latched values. mem_we=1 only in the first ACCESS cycle of a RAM write. A wait counter counts WAIT_STATES cycles. In the final ACCESS cycle, d_rdata is captured from the selected region (0 for writes). Then go to RESP.
- RESP: d_rvalid=1 for exactly one cycle; d_ready=0. Then go to IDLE.
- d_req while d_ready=0 is ignored. The requester must hold the request until it is accepted.
- Outside ACCESS: mem_sel=0, mem_we=0, mem_addr=0.

## Timing
- Reset values: instruction=0, instr_valid=0, d_ready=1 (state IDLE), d_rvalid=0, d_rdata=0, d_err=0, mem_sel=0, mem_we=0, mem_addr=0, wait counter=0.
- Mapped access latency: accept edge to d_rvalid = WAIT_STATES+2 cycles. Throughput is one access per WAIT_STATES+3 cycles.
- Error latency: d_rvalid 1 cycle after accept.
- Fetch latency: 1 cycle.
- Boundaries:
  - The address BASE+SIZE-1 hits the region; BASE+SIZE does not.
  - The address RAM_BASE+RAM_SIZE is unmapped.
- Reset asserted in any state forces IDLE the next edge. A pending write that has not reached ACCESS is never written. A write pulse in progress ends the same edge.
- d_rdata and d_err hold their values after RESP until the next capture.

## Configuration
- MEMCTRL_FAULT_LATCH_EN defined:
  - Adds outputs fault_addr (AW) and fault_valid (1).
  - On the first error response after reset, d_addr is captured and fault_valid is set. Both are sticky until reset; later faults do not overwrite them.
- MEMCTRL_FAULT_LATCH_EN undefined: these ports and registers do not exist, and error behaviour is otherwise identical.

## Test plan
- Reset, then pc=5, imem_data=0xE3A00001 -> next cycle instruction=0xE3A00001, instr_valid=1; pc=399 -> instruction=0, instr_valid=0.
- WAIT_STATES=0, read d_addr=400 with rom_rdata=0x000000FF -> mem_sel=001, mem_addr=0, d_rvalid 2 cycles after accept, d_rdata=0xFF, d_err=0.
- Write d_addr=90700, d_wdata=0x12345678 -> single mem_we pulse with mem_sel=100, mem_addr=0, mem_wdata=0x12345678; then a read of 220299 -> mem_addr=129599, no error.
- Write to 90400 (LUT) and read of 220300 -> mem_sel stays 0, d_rvalid 1 cycle after accept, d_err=1, d_rdata=0; with MEMCTRL_FAULT_LATCH_EN, fault_addr=90400 and fault_valid=1.
- WAIT_STATES=3, read of 90699 -> mem_sel=010, mem_addr=299 held for 4 cycles, d_rvalid at accept+5, d_ready low throughout.
- Reset asserted during ACCESS of a RAM write -> next cycle state IDLE, mem_we=0, d_rvalid never asserts for that request.
